// File: rtl/seg_display_mux_if.sv
// Display driver bundle: value/config sources on one side, board pin drives on the other.
interface seg_display_mux_if #(
    parameter int NUM_DIGITS = 8,
    parameter int PWM_BITS   = 4
);
    logic [4*NUM_DIGITS-1:0] val_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz_in;
    logic [PWM_BITS-1:0]     brightness_in;
    logic [6:0]              cat_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_done_out;

    modport master (
        output val_in, dp_in, blank_lz_in, brightness_in,
        input  cat_out, dp_out, an_out, frame_done_out
    );

    modport slave (
        input  val_in, dp_in, blank_lz_in, brightness_in,
        output cat_out, dp_out, an_out, frame_done_out
    );
endinterface

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver: frame-coherent shadow capture, leading-zero blanking,
// per-digit dp, PWM brightness per slot and a frame-done strobe. All outputs registered.
//
// state   | meaning
// ST_INIT | first cycle after reset release: capture shadows, counters held, outputs dark
// ST_RUN  | scanning digits; shadows recaptured at each frame wrap
module seg_display_mux #(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 100000,
    parameter int PWM_BITS       = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    seg_display_mux_if.slave  bus
);
    localparam int SW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (REFRESH_CYCLES < 2**PWM_BITS) begin : g_bad_refresh
        $error("REFRESH_CYCLES must be >= 2**PWM_BITS");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state, state_nxt;
    logic [SW-1:0]           slot_cnt;
    logic [DW-1:0]           digit_idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    shadow_blank;
    logic [PWM_BITS-1:0]     shadow_bri;
    logic                    capture, advance, frame_done_nxt;
    logic                    slot_last, digit_last;

    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              cat_q;
    logic                    dp_q, fd_q;

    assign slot_last  = (slot_cnt == SW'(REFRESH_CYCLES - 1));
    assign digit_last = (digit_idx == DW'(NUM_DIGITS - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= ST_INIT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        capture        = 1'b0;
        advance        = 1'b0;
        frame_done_nxt = 1'b0;
        case (state)
            ST_INIT: begin
                capture   = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                advance = 1'b1;
                if (slot_last && digit_last) begin
                    capture        = 1'b1;
                    frame_done_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            slot_cnt     <= '0;
            digit_idx    <= '0;
            shadow_val   <= '0;
            shadow_dp    <= '0;
            shadow_blank <= 1'b0;
            shadow_bri   <= '0;
        end else begin
            if (advance) begin
                if (slot_last) begin
                    slot_cnt  <= '0;
                    digit_idx <= digit_last ? '0 : digit_idx + DW'(1);
                end else begin
                    slot_cnt <= slot_cnt + SW'(1);
                end
            end
            if (capture) begin
                shadow_val   <= bus.val_in;
                shadow_dp    <= bus.dp_in;
                shadow_blank <= bus.blank_lz_in;
                shadow_bri   <= bus.brightness_in;
            end
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] h);
        case (h)
            4'h0: seg_decode = 7'b1000000;
            4'h1: seg_decode = 7'b1111001;
            4'h2: seg_decode = 7'b0100100;
            4'h3: seg_decode = 7'b0110000;
            4'h4: seg_decode = 7'b0011001;
            4'h5: seg_decode = 7'b0010010;
            4'h6: seg_decode = 7'b0000010;
            4'h7: seg_decode = 7'b1111000;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0010000;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b0000011;
            4'hC: seg_decode = 7'b1000110;
            4'hD: seg_decode = 7'b0100001;
            4'hE: seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    logic [NUM_DIGITS-1:0] blanked;
    logic                  upper_zero;
    logic [31:0]           on_cycles;
    logic                  digit_en;
    logic [3:0]            cur_nib;
    logic [NUM_DIGITS-1:0] an_nxt;

    // Walk down from the top digit; a digit is blanked only if it and everything above is zero.
    always_comb begin
        blanked    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (shadow_val[4*i +: 4] == 4'h0);
            blanked[i] = shadow_blank && upper_zero;
        end
    end

    always_comb begin
        on_cycles = ((32'(shadow_bri) + 32'd1) * 32'(REFRESH_CYCLES)) >> PWM_BITS;
        cur_nib   = shadow_val[{digit_idx, 2'b00} +: 4];
        digit_en  = (state == ST_RUN) && (32'(slot_cnt) < on_cycles) && !blanked[digit_idx];
        an_nxt    = '1;
        if (digit_en) an_nxt[digit_idx] = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            an_q  <= '1;
            cat_q <= 7'h7F;
            dp_q  <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            an_q  <= an_nxt;
            cat_q <= digit_en ? seg_decode(cur_nib) : 7'h7F;
            dp_q  <= digit_en ? ~shadow_dp[digit_idx] : 1'b1;
            fd_q  <= frame_done_nxt;
        end
    end

    assign bus.an_out         = an_q;
    assign bus.cat_out        = cat_q;
    assign bus.dp_out         = dp_q;
    assign bus.frame_done_out = fd_q;
endmodule
